// File: rtl/dualpreg_rf.sv
// -----------------------------------------------------------------------------
// dualpreg_rf
//   2-read / 1-write register file for the RNBIP-2 datapath.
//   - Write data is selected from four sources (ALU, A bus, B bus, OR2).
//   - Both read ports are registered (1-cycle latency) and update together on re.
//   - A per-register busy bit marks registers awaiting a multi-cycle producer:
//     rsv_en sets it, a write clears it; a same-cycle write+reserve leaves it set.
//   - Indices >= NREGS are ignored on write/reserve and read back as 0.
//
// Configuration macro: DUALPREG_RF_BYPASS_EN
//   defined   : write-first; a read of the index written this cycle returns the
//               new data and post-update busy.
//   undefined : read-first; such a read returns pre-write data and busy.
//
// Ports
//   clk         in   system clock, rising edge
//   clr_n       in   asynchronous active-low reset
//   we          in   write enable
//   mux_sel     in   write source: 00 alu_in, 01 a_in, 10 b_in, 11 or2
//   write_seg   in   write register index
//   alu_in      in   ALU result
//   a_in        in   A bus
//   b_in        in   B bus
//   or2         in   operand register 2
//   re          in   read enable for both ports
//   read_seg_a  in   read index, port A
//   read_seg_b  in   read index, port B
//   rsv_en      in   reserve enable (mark rsv_seg busy)
//   rsv_seg     in   register index to reserve
//   dataout_a   out  registered read data, port A
//   dataout_b   out  registered read data, port B
//   busy_a      out  registered busy flag of read_seg_a
//   busy_b      out  registered busy flag of read_seg_b
// -----------------------------------------------------------------------------
module dualpreg_rf #(
  parameter int                 DATA_W    = 8,
  parameter int                 NREGS     = 8,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  localparam int                ADDR_W    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              we,
  input  logic [1:0]        mux_sel,
  input  logic [ADDR_W-1:0] write_seg,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] or2,
  input  logic              re,
  input  logic [ADDR_W-1:0] read_seg_a,
  input  logic [ADDR_W-1:0] read_seg_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_seg,
  output logic [DATA_W-1:0] dataout_a,
  output logic [DATA_W-1:0] dataout_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic [DATA_W-1:0] dataout_a_q, dataout_a_d;
  logic [DATA_W-1:0] dataout_b_q, dataout_b_d;
  logic              busy_a_q, busy_a_d;
  logic              busy_b_q, busy_b_d;

  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_regs [NREGS];
  logic [NREGS-1:0]  rd_busy;

  // Write source select
  always_comb begin
    wdata = alu_in;
    case (mux_sel)
      2'b00:   wdata = alu_in;
      2'b01:   wdata = a_in;
      2'b10:   wdata = b_in;
      default: wdata = or2;
    endcase
  end

  // Next register/busy state. Indices are decoded by matching against every
  // valid slot, so an out-of-range index (non power-of-2 NREGS) hits nothing.
  // The reserve is applied after the write so a new producer wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NREGS; k++) begin
      if (we && (write_seg == ADDR_W'(k))) begin
        regs_d[k] = wdata;
        busy_d[k] = 1'b0;
      end
    end
    for (int k = 0; k < NREGS; k++) begin
      if (rsv_en && (rsv_seg == ADDR_W'(k))) begin
        busy_d[k] = 1'b1;
      end
    end
  end

  // Read source: post-update state for write-first, current state for read-first
`ifdef DUALPREG_RF_BYPASS_EN
  always_comb begin
    rd_regs = regs_d;
    rd_busy = busy_d;
  end
`else
  always_comb begin
    rd_regs = regs_q;
    rd_busy = busy_q;
  end
`endif

  // Read ports: hold when re=0; out-of-range index returns zero data and busy
  always_comb begin
    dataout_a_d = dataout_a_q;
    dataout_b_d = dataout_b_q;
    busy_a_d    = busy_a_q;
    busy_b_d    = busy_b_q;
    if (re) begin
      dataout_a_d = '0;
      dataout_b_d = '0;
      busy_a_d    = 1'b0;
      busy_b_d    = 1'b0;
      for (int k = 0; k < NREGS; k++) begin
        if (read_seg_a == ADDR_W'(k)) begin
          dataout_a_d = rd_regs[k];
          busy_a_d    = rd_busy[k];
        end
        if (read_seg_b == ADDR_W'(k)) begin
          dataout_b_d = rd_regs[k];
          busy_b_d    = rd_busy[k];
        end
      end
    end
  end

  // Register stage: storage, scoreboard and read outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
      busy_q      <= '0;
      dataout_a_q <= '0;
      dataout_b_q <= '0;
      busy_a_q    <= 1'b0;
      busy_b_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      dataout_a_q <= dataout_a_d;
      dataout_b_q <= dataout_b_d;
      busy_a_q    <= busy_a_d;
      busy_b_q    <= busy_b_d;
    end
  end

  assign dataout_a = dataout_a_q;
  assign dataout_b = dataout_b_q;
  assign busy_a    = busy_a_q;
  assign busy_b    = busy_b_q;

endmodule
